// File: rtl/rcc_pkg.sv
// Shared prescaler definitions: code constants, code normalization,
// code-to-terminal-count mapping and the update FSM state type.
package rcc_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = 9;

    localparam logic [CODE_W-1:0] CODE_DIV1   = 4'b0000;
    localparam logic [CODE_W-1:0] CODE_DIV2   = 4'b1000;
    localparam logic [CODE_W-1:0] CODE_DIV4   = 4'b1001;
    localparam logic [CODE_W-1:0] CODE_DIV8   = 4'b1010;
    localparam logic [CODE_W-1:0] CODE_DIV16  = 4'b1011;
    localparam logic [CODE_W-1:0] CODE_DIV64  = 4'b1100;
    localparam logic [CODE_W-1:0] CODE_DIV128 = 4'b1101;
    localparam logic [CODE_W-1:0] CODE_DIV256 = 4'b1110;
    localparam logic [CODE_W-1:0] CODE_DIV512 = 4'b1111;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } upd_state_e;

    // All 0xxx codes collapse to /1 so they compare equal to each other
    function automatic logic [CODE_W-1:0] norm_code(input logic [CODE_W-1:0] code);
        return code[CODE_W-1] ? code : CODE_DIV1;
    endfunction

    function automatic logic [CNT_W-1:0] code_to_tc(input logic [CODE_W-1:0] code);
        logic [CNT_W-1:0] tc;
        case (norm_code(code))
            CODE_DIV2:   tc = 9'd1;
            CODE_DIV4:   tc = 9'd3;
            CODE_DIV8:   tc = 9'd7;
            CODE_DIV16:  tc = 9'd15;
            CODE_DIV64:  tc = 9'd63;
            CODE_DIV128: tc = 9'd127;
            CODE_DIV256: tc = 9'd255;
            CODE_DIV512: tc = 9'd511;
            default:     tc = 9'd0;
        endcase
        return tc;
    endfunction

endpackage

// File: rtl/rcc_presc_decode.sv
// Combinational decoder: prescaler code to terminal count (N-1).
module rcc_presc_decode
    import rcc_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [8:0] tc_o
);

    assign tc_o = code_to_tc(code_i);

endmodule

// File: rtl/rcc_presc_update.sv
// Clock-enable prescaler whose divider code is only switched at a period
// boundary (or immediately in at-speed test mode), so no runt enables occur.
module rcc_presc_update
    import rcc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] presc_code,
    input  logic       atspeed_mode,
    output logic       clk_en,
    output logic [3:0] cur_code,
    output logic       busy,
    output logic       upd_done
);

    upd_state_e      state_q;
    logic [8:0]      cnt_q;
    logic [8:0]      cnt_d;
    logic            clk_en_q;
    logic [3:0]      cur_code_q;
    logic            busy_q;
    logic            upd_done_q;

    logic [8:0]      tc;
    logic [3:0]      req_code;
    logic            tc_hit;
    logic            code_diff;

    rcc_presc_decode u_decode (
        .code_i (cur_code_q),
        .tc_o   (tc)
    );

    assign req_code  = norm_code(presc_code);
    assign tc_hit    = (cnt_q == tc);
    assign code_diff = (req_code != cur_code_q);
    assign cnt_d     = tc_hit ? 9'd0 : cnt_q + 9'd1;

    // Free-running divider; the FSM overrides it only when a code is applied
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 9'd0;
            clk_en_q   <= 1'b0;
            cur_code_q <= CODE_DIV1;
            busy_q     <= 1'b0;
            upd_done_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            clk_en_q   <= tc_hit;
            upd_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (code_diff) begin
                        state_q <= ST_PENDING;
                        busy_q  <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (!code_diff) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (atspeed_mode) begin
                        cur_code_q <= req_code;
                        cnt_q      <= 9'd0;
                        clk_en_q   <= 1'b0;
                        upd_done_q <= 1'b1;
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                    end else if (tc_hit) begin
                        // Old period completes on this edge; new code starts fresh
                        cur_code_q <= req_code;
                        upd_done_q <= 1'b1;
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clk_en   = clk_en_q;
    assign cur_code = cur_code_q;
    assign busy     = busy_q;
    assign upd_done = upd_done_q;

endmodule

// File: tb/tb_rcc_presc_update.sv
// Scoreboard bench for rcc_presc_update: stimulus queues the hand-derived
// per-edge outputs, a monitor compares them one time unit after each edge.
module tb_rcc_presc_update;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] presc_code;
    logic       atspeed_mode;
    logic       clk_en;
    logic [3:0] cur_code;
    logic       busy;
    logic       upd_done;

    always #5 clk = ~clk;

    rcc_presc_update dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .presc_code   (presc_code),
        .atspeed_mode (atspeed_mode),
        .clk_en       (clk_en),
        .cur_code     (cur_code),
        .busy         (busy),
        .upd_done     (upd_done)
    );

    typedef struct {
        string      name;
        logic       chk;
        logic       en;
        logic       bsy;
        logic       upd;
        logic [3:0] cur;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // One edge: queue the expected outputs after it, drive inputs, advance
    task automatic step(input logic rst, input logic [3:0] code, input logic ats,
                        input string name, input logic chk, input logic en,
                        input logic bsy, input logic upd, input logic [3:0] cur);
        exp_t e;
        e.name = name;
        e.chk  = chk;
        e.en   = en;
        e.bsy  = bsy;
        e.upd  = upd;
        e.cur  = cur;
        exp_q.push_back(e);
        rst_n        = rst;
        presc_code   = code;
        atspeed_mode = ats;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold(input int n, input logic [3:0] code, input logic ats,
                        input string name, input logic en, input logic bsy,
                        input logic upd, input logic [3:0] cur);
        for (int i = 0; i < n; i++)
            step(1'b1, code, ats, name, 1'b1, en, bsy, upd, cur);
    endtask

    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                n_tests++;
                if ({clk_en, busy, upd_done, cur_code} !== {e.en, e.bsy, e.upd, e.cur}) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got en=%b busy=%b upd=%b cur=%b want en=%b busy=%b upd=%b cur=%b",
                             e.name, cyc, clk_en, busy, upd_done, cur_code,
                             e.en, e.bsy, e.upd, e.cur);
                end
            end
        end
    end

    initial begin
        // Reset, then release with /2 requested
        step(1'b0, 4'b1000, 1'b0, "reset", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 4'b1000, 1'b0, "reset", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        step(1'b1, 4'b1000, 1'b0, "a_req2", 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        step(1'b1, 4'b1000, 1'b0, "a_apply2", 1'b1, 1'b1, 1'b0, 1'b1, 4'b1000);
        for (int i = 3; i <= 6; i++)
            step(1'b1, 4'b1000, 1'b0, "a_div2", 1'b1, (i % 2 == 0), 1'b0, 1'b0, 4'b1000);
        step(1'b1, 4'b0000, 1'b0, "a_req1", 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000);
        step(1'b1, 4'b0000, 1'b0, "a_apply1", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
        hold(4, 4'b0000, 1'b0, "a_div1", 1'b1, 1'b0, 1'b0, 4'b0000);

        // 0xxx codes all normalize to /1
        hold(3, 4'b0101, 1'b0, "b_0101", 1'b1, 1'b0, 1'b0, 4'b0000);
        hold(3, 4'b0111, 1'b0, "b_0111", 1'b1, 1'b0, 1'b0, 4'b0000);

        // Go to /8, then request /16 at cnt=3
        step(1'b1, 4'b1010, 1'b0, "c_req8", 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        step(1'b1, 4'b1010, 1'b0, "c_apply8", 1'b1, 1'b1, 1'b0, 1'b1, 4'b1010);
        hold(3, 4'b1010, 1'b0, "c_div8", 1'b0, 1'b0, 1'b0, 4'b1010);
        hold(4, 4'b1011, 1'b0, "c_pend16", 1'b0, 1'b1, 1'b0, 4'b1010);
        step(1'b1, 4'b1011, 1'b0, "c_apply16", 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011);
        hold(15, 4'b1011, 1'b0, "c_gap16", 1'b0, 1'b0, 1'b0, 4'b1011);
        step(1'b1, 4'b1011, 1'b0, "c_en16", 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);

        // At-speed jump to /512, then a 3-cycle glitch to /2 that is withdrawn
        step(1'b1, 4'b1111, 1'b1, "d_req512", 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011);
        step(1'b1, 4'b1111, 1'b1, "d_apply512", 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111);
        hold(3, 4'b1000, 1'b0, "d_glitch", 1'b0, 1'b1, 1'b0, 4'b1111);
        step(1'b1, 4'b1111, 1'b0, "d_cancel", 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111);
        hold(507, 4'b1111, 1'b0, "d_gap512", 1'b0, 1'b0, 1'b0, 4'b1111);
        step(1'b1, 4'b1111, 1'b0, "d_en512", 1'b1, 1'b1, 1'b0, 1'b0, 4'b1111);

        // cnt=10 under /512, at-speed request for /4
        hold(10, 4'b1111, 1'b0, "e_cnt", 1'b0, 1'b0, 1'b0, 4'b1111);
        step(1'b1, 4'b1001, 1'b1, "e_req4", 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111);
        step(1'b1, 4'b1001, 1'b1, "e_apply4", 1'b1, 1'b0, 1'b0, 1'b1, 4'b1001);
        hold(3, 4'b1001, 1'b0, "e_gap4", 1'b0, 1'b0, 1'b0, 4'b1001);
        step(1'b1, 4'b1001, 1'b0, "e_en4", 1'b1, 1'b1, 1'b0, 1'b0, 4'b1001);
        hold(3, 4'b1001, 1'b0, "e_gap4b", 1'b0, 1'b0, 1'b0, 4'b1001);
        step(1'b1, 4'b1001, 1'b0, "e_en4b", 1'b1, 1'b1, 1'b0, 1'b0, 4'b1001);

        // Reset during a pending /64 request discards it
        hold(2, 4'b1100, 1'b0, "f_pend64", 1'b0, 1'b1, 1'b0, 4'b1001);
        step(1'b0, 4'b1100, 1'b0, "f_reset", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
        hold(4, 4'b0000, 1'b0, "f_after", 1'b1, 1'b0, 1'b0, 4'b0000);
        step(1'b1, 4'b1100, 1'b0, "f_req64", 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        step(1'b1, 4'b1100, 1'b0, "f_apply64", 1'b1, 1'b1, 1'b0, 1'b1, 4'b1100);
        step(1'b1, 4'b1100, 1'b0, "f_div64", 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100);

        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d entries left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
